conv_kernel_loader: RTL and testbench
=====================================

Name: conv_kernel_loader

Overview:
- Receives convolution reference (kernel) coefficients from the Ethernet side on clke.
- Distributes them to the coefficient RAMs of N_BLK convolution blocks per channel, for N_CH independent channels.
- Kernel RAMs are double-buffered: writes go to the shadow bank, and the active bank swaps only after a complete frame passes its checksum. Reloading therefore never corrupts a kernel in use.
- Sits between the Ethernet receive path and the convolution array, replacing fixed single-bank kernel loading.

Parameters:
- N_BLK, 4, convolution blocks per channel.
- MULT_N, 25, coefficients per block (time-multiplex factor).
- N_CH, 2, independent channels, each with its own kernel.
- KW, 16, coefficient width, two's complement.
- TIMEOUT, 4096, max clke cycles between coef_en strobes inside a frame.
- ADDR_W, $clog2(MULT_N), derived local address width.
- CHW, max(1,$clog2(N_CH)), derived channel-select width.
- LEN, N_BLK*MULT_N, derived coefficients per frame (default 100).

Ports:
- clke  in  1  Ethernet clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse; opens a frame for channel ch_sel.
- ch_sel  in  CHW  target channel, sampled on load_start.
- coef_en  in  1  coefficient-valid strobe.
- COEF  in  KW  coefficient word, valid with coef_en.
- koef_we  out  N_CH*N_BLK  one-hot RAM write enable; bit index = ch*N_BLK + blk.
- KOEF_OUT  out  KW  registered coefficient.
- KOEF_ADDR  out  ADDR_W+1  {shadow bank bit, word index within block}.
- active_bank  out  N_CH  per-channel bank the convolution reads (level).
- busy  out  1  high from load_start until DONE/ERR is left.
- load_done  out  1  one-cycle pulse: frame accepted, bank swapped.
- load_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  2  held until next load_start: 0 none, 1 checksum, 2 timeout, 3 ch_sel >= N_CH.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- FSM states: IDLE, LOAD, CHECK, DONE, ERR.
- IDLE:
  - coef_en is ignored.
  - load_start with ch_sel < N_CH → LOAD. Latch ch_sel, clear word/blk counters and sum, set busy.
  - load_start with ch_sel >= N_CH → ERR with code 3.
- LOAD, per coef_en:
  - Register KOEF_OUT = COEF and KOEF_ADDR = {~active_bank[ch], word}.
  - Assert koef_we[ch*N_BLK+blk] for exactly one cycle. Outputs appear 1 cycle after the strobe.
  - Sum += COEF, mod 2^KW.
  - word increments; when word == MULT_N-1 it wraps to 0 and blk increments. No divider is used.
  - After the LEN-th coefficient → CHECK.
- CHECK: the next coef_en carries the checksum word. No RAM write occurs. Match → DONE; mismatch → ERR code 1.
- Timeout: a watchdog counter clears on every coef_en. If it reaches TIMEOUT while in LOAD or CHECK → ERR code 2.
- DONE (1 cycle):
  - Toggle active_bank[ch]; pulse load_done; drop busy; → IDLE.
  - Other channels' bits are untouched.
- ERR (1 cycle): pulse load_err, drop busy, → IDLE. active_bank is unchanged.
- load_start while in LOAD/CHECK: silently restart the frame. Counters and sum are cleared, no error pulse. The new ch_sel is honoured.
- load_start coinciding with coef_en in IDLE: load_start wins; that COEF is discarded.
- Reset mid-frame: everything returns to reset values. active_bank = 0 on all channels. A partial shadow bank is harmless.
- The consumer resynchronises active_bank into its own clock domain. This block guarantees each bit toggles at most once per LEN+1 strobes.

Decomposition:
- Shared package conv_pkg holds:
  - The err_code enumeration.
  - FSM state encoding.
  - Default N_BLK, MULT_N, NUM_OPORA constants shared with the convolution top.
- One sub-module, conv_kernel_addr_gen: the word/blk counters with wrap logic and one-hot koef_we decode.

Test Plan:
- Load ch0 with coefficients 1..100, then checksum 5050 mod 65536 = 5050 → 100 koef_we pulses:
  - blk0 receives words 0..24 with COEF 1..25 at KOEF_ADDR {1,0..24}.
  - One load_done, active_bank = 01.
- Same frame but checksum 5051 → load_err, err_code = 1, active_bank unchanged, all 100 writes still seen.
- Start ch1, send 40 coefficients, then idle 4096 cycles → load_err, err_code = 2, busy low. Next full load succeeds and sets active_bank = 10.
- Restart: after 30 coefficients issue load_start ch0, then a full valid frame → exactly one load_done, no load_err, KOEF_ADDR word restarts at 0.
- ch_sel = 2 with N_CH = 2 → load_err next cycle, err_code = 3, no koef_we activity.
- Assert rst at coefficient 60 of a frame → all outputs 0 within the reset. A subsequent full frame completes normally with active_bank = 01.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default sizes for the convolution kernel path.
package conv_pkg;

    localparam int N_BLK_DEF     = 4;
    localparam int MULT_N_DEF    = 25;
    localparam int NUM_OPORA_DEF = N_BLK_DEF * MULT_N_DEF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_CHSEL   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/conv_kernel_loader_if.sv
// Bus between the Ethernet receive side, the kernel loader and the kernel RAMs.
interface conv_kernel_loader_if
    import conv_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int N_BLK  = N_BLK_DEF,
    parameter int MULT_N = MULT_N_DEF,
    parameter int KW     = 16
);
    localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W = $clog2(MULT_N);

    logic                    load_start;
    logic [CHW-1:0]          ch_sel;
    logic                    coef_en;
    logic [KW-1:0]           COEF;
    logic [N_CH*N_BLK-1:0]   koef_we;
    logic [KW-1:0]           KOEF_OUT;
    logic [ADDR_W:0]         KOEF_ADDR;
    logic [N_CH-1:0]         active_bank;
    logic                    busy;
    logic                    load_done;
    logic                    load_err;
    err_code_e               err_code;

    modport master (
        output load_start, ch_sel, coef_en, COEF,
        input  koef_we, KOEF_OUT, KOEF_ADDR, active_bank, busy, load_done, load_err, err_code
    );

    modport slave (
        input  load_start, ch_sel, coef_en, COEF,
        output koef_we, KOEF_OUT, KOEF_ADDR, active_bank, busy, load_done, load_err, err_code
    );

endinterface

// File: rtl/conv_kernel_addr_gen.sv
// Word/block counters for one kernel frame plus the one-hot RAM select decode.
module conv_kernel_addr_gen #(
    parameter int N_BLK  = 4,
    parameter int MULT_N = 25,
    parameter int N_CH   = 2,
    localparam int ADDR_W = $clog2(MULT_N),
    localparam int BLKW   = (N_BLK > 1) ? $clog2(N_BLK) : 1,
    localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int WE_W   = N_CH * N_BLK
) (
    input  logic              clke,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [CHW-1:0]    ch,
    output logic [ADDR_W-1:0] word,
    output logic              last,
    output logic [WE_W-1:0]   we_dec
);
    logic [ADDR_W-1:0] word_q, word_d;
    logic [BLKW-1:0]   blk_q, blk_d;
    logic              word_wrap;

    // Next counter values: word wraps at MULT_N-1 and carries into blk.
    always_comb begin
        word_d    = word_q;
        blk_d     = blk_q;
        word_wrap = (word_q == ADDR_W'(MULT_N - 1));
        if (clr) begin
            word_d = '0;
            blk_d  = '0;
        end else if (adv) begin
            if (word_wrap) begin
                word_d = '0;
                blk_d  = (blk_q == BLKW'(N_BLK - 1)) ? '0 : blk_q + 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            blk_q  <= '0;
        end else begin
            word_q <= word_d;
            blk_q  <= blk_d;
        end
    end

    assign word   = word_q;
    assign last   = (word_q == ADDR_W'(MULT_N - 1)) && (blk_q == BLKW'(N_BLK - 1));
    assign we_dec = WE_W'(1) << (int'(ch) * N_BLK + int'(blk_q));

endmodule

// File: rtl/conv_kernel_loader.sv
// Loads per-channel convolution kernels into the shadow RAM bank and swaps banks
// only after the frame checksum matches.
module conv_kernel_loader
    import conv_pkg::*;
#(
    parameter int N_BLK   = N_BLK_DEF,
    parameter int MULT_N  = MULT_N_DEF,
    parameter int N_CH    = 2,
    parameter int KW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic               clke,
    input  logic               rst,
    conv_kernel_loader_if.slave bus
);
    localparam int ADDR_W = $clog2(MULT_N);
    localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CHW1   = CHW + 1;
    localparam int WE_W   = N_CH * N_BLK;
    localparam int WDW    = $clog2(TIMEOUT + 1);

    state_e                   state_q, state_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic signed [KW-1:0]     sum_q, sum_d;
    logic [WDW-1:0]           wdog_q, wdog_d;
    logic [WE_W-1:0]          koef_we_q, koef_we_d;
    logic [KW-1:0]            koef_out_q, koef_out_d;
    logic [ADDR_W:0]          koef_addr_q, koef_addr_d;
    logic [N_CH-1:0]          active_bank_q, active_bank_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    err_code_e                err_code_q, err_code_d;

    logic                     gen_clr, gen_adv, gen_last;
    logic [ADDR_W-1:0]        gen_word;
    logic [WE_W-1:0]          gen_we;
    logic [CHW1-1:0]          ch_ext;
    logic                     ch_ok;

    assign ch_ext = {1'b0, bus.ch_sel};
    assign ch_ok  = (ch_ext < CHW1'(N_CH));

    conv_kernel_addr_gen #(
        .N_BLK  (N_BLK),
        .MULT_N (MULT_N),
        .N_CH   (N_CH)
    ) u_addr_gen (
        .clke   (clke),
        .rst    (rst),
        .clr    (gen_clr),
        .adv    (gen_adv),
        .ch     (ch_q),
        .word   (gen_word),
        .last   (gen_last),
        .we_dec (gen_we)
    );

    // Frame FSM: start/restart, coefficient writes, checksum, watchdog, bank swap.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        sum_d         = sum_q;
        wdog_d        = '0;
        koef_we_d     = '0;
        koef_out_d    = koef_out_q;
        koef_addr_d   = koef_addr_q;
        active_bank_d = active_bank_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        gen_clr       = 1'b0;
        gen_adv       = 1'b0;
        unique case (state_q)
            S_IDLE, S_LOAD, S_CHECK: begin
                if (bus.load_start) begin
                    // A new start always wins, including a silent restart mid-frame.
                    gen_clr    = 1'b1;
                    sum_d      = '0;
                    busy_d     = 1'b1;
                    ch_d       = bus.ch_sel;
                    err_code_d = ERR_NONE;
                    if (ch_ok) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = ERR_CHSEL;
                    end
                end else if (state_q != S_IDLE) begin
                    if (bus.coef_en) begin
                        if (state_q == S_LOAD) begin
                            gen_adv     = 1'b1;
                            koef_we_d   = gen_we;
                            koef_out_d  = bus.COEF;
                            koef_addr_d = {~active_bank_q[ch_q], gen_word};
                            sum_d       = sum_q + $signed(bus.COEF);
                            if (gen_last) begin
                                state_d = S_CHECK;
                            end
                        end else if ($signed(bus.COEF) == sum_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_ERR;
                            err_code_d = ERR_CSUM;
                        end
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                        if (wdog_q == WDW'(TIMEOUT - 1)) begin
                            state_d    = S_ERR;
                            err_code_d = ERR_TIMEOUT;
                        end
                    end
                end
            end
            S_DONE: begin
                active_bank_d[ch_q] = ~active_bank_q[ch_q];
                done_d              = 1'b1;
                busy_d              = 1'b0;
                state_d             = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset returns every output and bank to 0.
    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            sum_q         <= '0;
            wdog_q        <= '0;
            koef_we_q     <= '0;
            koef_out_q    <= '0;
            koef_addr_q   <= '0;
            active_bank_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            sum_q         <= sum_d;
            wdog_q        <= wdog_d;
            koef_we_q     <= koef_we_d;
            koef_out_q    <= koef_out_d;
            koef_addr_q   <= koef_addr_d;
            active_bank_q <= active_bank_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.koef_we     = koef_we_q;
    assign bus.KOEF_OUT    = koef_out_q;
    assign bus.KOEF_ADDR   = koef_addr_q;
    assign bus.active_bank = active_bank_q;
    assign bus.busy        = busy_q;
    assign bus.load_done   = done_q;
    assign bus.load_err    = err_q;
    assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_conv_kernel_loader.sv
// Scoreboard bench for conv_kernel_loader: stimulus pushes expected RAM writes
// and frame results, a monitor pops them when the DUT presents them.
module tb_conv_kernel_loader;
    import conv_pkg::*;

    localparam int N_CH    = 3;
    localparam int N_BLK   = 4;
    localparam int MULT_N  = 25;
    localparam int KW      = 16;
    localparam int TIMEOUT = 4096;
    localparam int LEN     = N_BLK * MULT_N;
    localparam int WE_W    = N_CH * N_BLK;
    localparam int CHW     = 2;

    logic clke = 1'b0;
    logic rst  = 1'b1;
    always #5 clke = ~clke;

    conv_kernel_loader_if #(.N_CH(N_CH), .N_BLK(N_BLK), .MULT_N(MULT_N), .KW(KW)) bus();

    conv_kernel_loader #(
        .N_BLK(N_BLK), .MULT_N(MULT_N), .N_CH(N_CH), .KW(KW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clke (clke),
        .rst  (rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [N_CH-1:0] exp_bank = '0;
    // {koef_we, KOEF_OUT, KOEF_ADDR}
    logic [WE_W+KW+6-1:0] exp_wr[$];
    // {load_done, load_err, err_code, active_bank, busy}
    logic [7:0] exp_res[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        bus.coef_en = 1'b1;
        bus.COEF    = v;
        @(negedge clke);
        bus.coef_en = 1'b0;
    endtask

    task automatic start(input int ch, input bit with_coef);
        bus.load_start = 1'b1;
        bus.ch_sel     = CHW'(ch);
        if (with_coef) begin
            bus.coef_en = 1'b1;
            bus.COEF    = 16'd999;
        end
        @(negedge clke);
        bus.load_start = 1'b0;
        bus.coef_en    = 1'b0;
    endtask

    // Sends coefficients 1..n to channel ch, expecting a shadow-bank write for each.
    task automatic frame(input int ch, input int n);
        logic sh;
        sh = ~exp_bank[ch];
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({WE_W'(1) << (ch * N_BLK + i / MULT_N), 16'(i + 1), sh, 5'(i % MULT_N)});
            strobe(16'(i + 1));
        end
    endtask

    task automatic push_res(input bit done, input bit err, input logic [1:0] code);
        exp_res.push_back({done, err, code, exp_bank, 1'b0});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(bus.koef_we),     64'd0);
        check({tag, "_out"},   64'(bus.KOEF_OUT),    64'd0);
        check({tag, "_addr"},  64'(bus.KOEF_ADDR),   64'd0);
        check({tag, "_bank"},  64'(bus.active_bank), 64'd0);
        check({tag, "_flags"}, 64'({bus.busy, bus.load_done, bus.load_err, bus.err_code}), 64'd0);
    endtask

    // Monitor: every write strobe and every done/err pulse must match the head of its queue.
    initial begin
        forever begin
            @(negedge clke);
            if (bus.koef_we != '0) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got we=%0h addr=%0h expected none", bus.koef_we, bus.KOEF_ADDR);
                end else begin
                    check("write", 64'({bus.koef_we, bus.KOEF_OUT, bus.KOEF_ADDR}), 64'(exp_wr.pop_front()));
                end
            end
            if (bus.load_done || bus.load_err) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got done=%0b err=%0b code=%0d expected none",
                             bus.load_done, bus.load_err, bus.err_code);
                end else begin
                    check("result", 64'({bus.load_done, bus.load_err, bus.err_code, bus.active_bank, bus.busy}),
                          64'(exp_res.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.load_start = 1'b0;
        bus.ch_sel     = '0;
        bus.coef_en    = 1'b0;
        bus.COEF       = '0;
        repeat (3) @(negedge clke);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clke);

        // Good ch0 frame; the COEF arriving with load_start is discarded.
        start(0, 1'b1);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        frame(0, LEN);
        exp_bank[0] = 1'b1;
        push_res(1'b1, 1'b0, 2'd0);
        strobe(16'd5050);
        repeat (5) @(negedge clke);
        check("bank_after_ch0", 64'(bus.active_bank), 64'b001);

        // Same frame with a wrong checksum: writes still happen, bank kept.
        start(0, 1'b0);
        frame(0, LEN);
        push_res(1'b0, 1'b1, 2'd1);
        strobe(16'd5051);
        repeat (5) @(negedge clke);
        check("err_code_csum_held", 64'(bus.err_code), 64'd1);

        // ch1 stalls after 40 coefficients until the watchdog fires.
        start(1, 1'b0);
        frame(1, 40);
        push_res(1'b0, 1'b1, 2'd2);
        repeat (TIMEOUT + 4) @(negedge clke);
        check("busy_after_timeout", 64'(bus.busy), 64'd0);
        check("err_code_timeout", 64'(bus.err_code), 64'd2);
        start(1, 1'b0);
        frame(1, LEN);
        exp_bank[1] = 1'b1;
        push_res(1'b1, 1'b0, 2'd0);
        strobe(16'd5050);
        repeat (5) @(negedge clke);
        check("bank_after_ch1", 64'(bus.active_bank), 64'b011);

        // Restart after 30 coefficients; only the second frame completes.
        start(0, 1'b0);
        frame(0, 30);
        start(0, 1'b0);
        frame(0, LEN);
        exp_bank[0] = 1'b0;
        push_res(1'b1, 1'b0, 2'd0);
        strobe(16'd5050);
        repeat (5) @(negedge clke);
        check("bank_after_restart", 64'(bus.active_bank), 64'b010);

        // Out-of-range channel; following strobes must not write anything.
        push_res(1'b0, 1'b1, 2'd3);
        start(3, 1'b0);
        strobe(16'd7);
        strobe(16'd8);
        strobe(16'd9);
        repeat (5) @(negedge clke);
        check("err_code_chsel", 64'(bus.err_code), 64'd3);

        // Reset in the middle of a frame, then a clean frame.
        start(0, 1'b0);
        frame(0, 60);
        @(negedge clke);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_bank = '0;
        repeat (2) @(negedge clke);
        rst = 1'b0;
        repeat (2) @(negedge clke);
        start(0, 1'b0);
        frame(0, LEN);
        exp_bank[0] = 1'b1;
        push_res(1'b1, 1'b0, 2'd0);
        strobe(16'd5050);
        repeat (5) @(negedge clke);
        check("bank_after_reset_frame", 64'(bus.active_bank), 64'b001);

        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        check("pending_results", 64'(exp_res.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
